// File: rtl/tensor_product.sv
// tensor_product: tiled outer-product engine for signed fixed-point vectors.
//   result[r][c] = sat((a[r] * b[c]) >>> FRACTION_WIDTH)
// A TILING_V x TILING_H tile of the result matrix is computed every BUSY cycle.
// Tiles are visited row-major (column tile first, then row tile).
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   start  - one-cycle request; accepted in IDLE/DONE, ignored while BUSY
//   a      - A_VECTOR_LEN signed elements, element r at [r*A_CELL_WIDTH +: A_CELL_WIDTH]
//   b      - B_VECTOR_LEN signed elements, element c at [c*B_CELL_WIDTH +: B_CELL_WIDTH]
//   result - flat matrix, element (r,c) at [(r*B_VECTOR_LEN+c)*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH]
//   valid  - result complete and stable
//   error  - at least one element saturated in the current product (sticky)
module tensor_product #(
  parameter int A_VECTOR_LEN      = 5,
  parameter int B_VECTOR_LEN      = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 12,
  parameter int FRACTION_WIDTH    = 1,
  parameter int TILING_H          = 2,
  parameter int TILING_V          = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]                   a,
  input  logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]                   b,
  output logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                                   valid,
  output logic                                                   error
);

  localparam int PW  = A_CELL_WIDTH + B_CELL_WIDTH;
  localparam int RCW = RESULT_CELL_WIDTH;
  // Comparison width wide enough for both the product and the result range.
  localparam int EW  = ((PW > RCW) ? PW : RCW) + 1;
  localparam int NRT = (A_VECTOR_LEN + TILING_V - 1) / TILING_V;
  localparam int NCT = (B_VECTOR_LEN + TILING_H - 1) / TILING_H;
  localparam int RTW = (NRT > 1) ? $clog2(NRT) : 1;
  localparam int CTW = (NCT > 1) ? $clog2(NCT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                                 state;
  logic [RTW-1:0]                         row_tile;
  logic [CTW-1:0]                         col_tile;
  logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]   a_hold;
  logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]   b_hold;

  logic signed [RCW-1:0] lane_val [TILING_V][TILING_H];
  logic                  lane_wr  [TILING_V][TILING_H];
  int                    lane_pos [TILING_V][TILING_H];
  logic                  any_sat;

  logic accept;
  assign accept = start && (state != BUSY);

  // Floor shift then clamp; MSB of the return value flags a clamp.
  function automatic logic [RCW:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    logic signed [EW-1:0] e;
    logic signed [EW-1:0] mx;
    logic signed [EW-1:0] mn;
    s  = p >>> FRACTION_WIDTH;
    e  = EW'(s);
    mx = {{(EW-RCW+1){1'b0}}, {(RCW-1){1'b1}}};
    mn = ~mx;
    if (e > mx)      return {1'b1, mx[RCW-1:0]};
    else if (e < mn) return {1'b1, mn[RCW-1:0]};
    else             return {1'b0, e[RCW-1:0]};
  endfunction

  // Operand copies are held so a and b may change freely while BUSY.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_hold <= a;
      b_hold <= b;
    end
  end

  // Tile lanes: one multiplier per (i,j) position of the current tile.
  always_comb begin
    int r;
    int c;
    int rs;
    int cs;
    logic signed [A_CELL_WIDTH-1:0] as;
    logic signed [B_CELL_WIDTH-1:0] bs;
    logic signed [PW-1:0]           prod;
    logic [RCW:0]                   rsat;
    any_sat = 1'b0;
    for (int i = 0; i < TILING_V; i++) begin
      for (int j = 0; j < TILING_H; j++) begin
        r    = int'(row_tile) * TILING_V + i;
        c    = int'(col_tile) * TILING_H + j;
        // Edge-tile lanes past the matrix boundary are masked off.
        lane_wr[i][j]  = (r < A_VECTOR_LEN) && (c < B_VECTOR_LEN);
        rs   = (r < A_VECTOR_LEN) ? r : 0;
        cs   = (c < B_VECTOR_LEN) ? c : 0;
        as   = a_hold[rs*A_CELL_WIDTH +: A_CELL_WIDTH];
        bs   = b_hold[cs*B_CELL_WIDTH +: B_CELL_WIDTH];
        prod = as * bs;
        rsat = round_sat(prod);
        lane_val[i][j] = rsat[RCW-1:0];
        lane_pos[i][j] = rs * B_VECTOR_LEN + cs;
        any_sat        = any_sat | (lane_wr[i][j] & rsat[RCW]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      row_tile <= '0;
      col_tile <= '0;
      result   <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            valid    <= 1'b0;
            error    <= 1'b0;
            row_tile <= '0;
            col_tile <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < TILING_V; i++) begin
            for (int j = 0; j < TILING_H; j++) begin
              if (lane_wr[i][j])
                result[lane_pos[i][j]*RCW +: RCW] <= lane_val[i][j];
            end
          end
          if (any_sat) error <= 1'b1;
          if (col_tile == CTW'(NCT-1)) begin
            col_tile <= '0;
            if (row_tile == RTW'(NRT-1)) begin
              row_tile <= '0;
              valid    <= 1'b1;
              state    <= DONE;
            end else begin
              row_tile <= row_tile + 1'b1;
            end
          end else begin
            col_tile <= col_tile + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_product.sv
// Testbench for tensor_product: default 5x5 instance plus a 3x4 non-square
// instance (TILING_V=2, TILING_H=3), checked against an arithmetic model.
module tb_tensor_product;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [39:0]  a = '0;
  logic [39:0]  b = '0;
  logic [299:0] result;
  logic         valid;
  logic         error;

  logic         start2 = 1'b0;
  logic [23:0]  a2 = '0;
  logic [31:0]  b2 = '0;
  logic [143:0] result2;
  logic         valid2;
  logic         error2;

  int n_cmp = 0;
  int n_bad = 0;

  int av [5];
  int bv [5];
  int exp_m [25];
  bit exp_err;
  int av2 [3];
  int bv2 [4];
  int exp2 [12];
  bit exp_err2;

  always #5 clk = ~clk;

  tensor_product dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .result(result), .valid(valid), .error(error)
  );

  tensor_product #(
    .A_VECTOR_LEN(3), .B_VECTOR_LEN(4), .TILING_V(2), .TILING_H(3)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .result(result2), .valid(valid2), .error(error2)
  );

  // Reference: exact product, floor-divided by 2, clamped to 12-bit signed.
  function automatic int model_elem(input int x, input int y, output bit sat);
    int p;
    int q;
    p = x * y;
    q = (p >= 0) ? p / 2 : -((-p + 1) / 2);
    sat = 1'b0;
    if (q > 2047)  begin q = 2047;  sat = 1'b1; end
    if (q < -2048) begin q = -2048; sat = 1'b1; end
    return q;
  endfunction

  task automatic drive_ab();
    for (int i = 0; i < 5; i++) begin
      a[i*8 +: 8] = 8'(av[i]);
      b[i*8 +: 8] = 8'(bv[i]);
    end
  endtask

  task automatic build_expect();
    bit s;
    exp_err = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        exp_m[r*5+c] = model_elem(av[r], bv[c], s);
        exp_err |= s;
      end
  endtask

  task automatic randomize_ab();
    for (int i = 0; i < 5; i++) begin
      av[i] = $urandom_range(0, 255) - 128;
      bv[i] = $urandom_range(0, 255) - 128;
    end
  endtask

  function automatic int got_elem(input int r, input int c);
    logic signed [11:0] v;
    v = result[(r*5+c)*12 +: 12];
    return int'(v);
  endfunction

  function automatic int got_elem2(input int r, input int c);
    logic signed [11:0] v;
    v = result2[(r*4+c)*12 +: 12];
    return int'(v);
  endfunction

  // Drive operands, pulse start; returns #1 after the edge that samples start.
  task automatic pulse_start();
    drive_ab();
    build_expect();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (valid === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %h required 0", result); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", valid); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b required 0", error); end
    n_cmp++; if (result2 !== '0 || valid2 !== 1'b0 || error2 !== 1'b0) begin
      n_bad++; $display("FAIL reset_dut2: got v=%b e=%b required 0/0", valid2, error2);
    end
    rst = 1'b1;
  endtask

  task automatic test_reference();
    int n;
    av = '{10, 20, 30, 40, -50};
    bv = '{5, 4, -3, 2, 1};
    pulse_start();
    wait_valid(n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL ref_latency: got %0d required 9", n); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL ref_error: got %b required 0", error); end
    n_cmp++; if (got_elem(0,0) !== 25)   begin n_bad++; $display("FAIL ref_00: got %0d required 25", got_elem(0,0)); end
    n_cmp++; if (got_elem(2,2) !== -45)  begin n_bad++; $display("FAIL ref_22: got %0d required -45", got_elem(2,2)); end
    n_cmp++; if (got_elem(4,0) !== -125) begin n_bad++; $display("FAIL ref_40: got %0d required -125", got_elem(4,0)); end
    n_cmp++; if (got_elem(4,2) !== 75)   begin n_bad++; $display("FAIL ref_42: got %0d required 75", got_elem(4,2)); end
    n_cmp++; if (got_elem(3,4) !== 20)   begin n_bad++; $display("FAIL ref_34: got %0d required 20", got_elem(3,4)); end
    n_cmp++; if (got_elem(1,1) !== 40)   begin n_bad++; $display("FAIL ref_11: got %0d required 40", got_elem(1,1)); end
    for (int k = 0; k < 25; k++) begin
      n_cmp++;
      if (got_elem(k/5, k%5) !== exp_m[k]) begin
        n_bad++; $display("FAIL ref_elem%0d: got %0d required %0d", k, got_elem(k/5, k%5), exp_m[k]);
      end
    end
  endtask

  task automatic test_rounding();
    int n;
    int cases [2][3] = '{'{1, -3, -2}, '{3, 1, 1}};
    for (int t = 0; t < 2; t++) begin
      randomize_ab();
      av[0] = cases[t][0];
      bv[0] = cases[t][1];
      pulse_start();
      wait_valid(n);
      n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL round_latency%0d: got %0d required 9", t, n); end
      n_cmp++;
      if (got_elem(0,0) !== cases[t][2]) begin
        n_bad++; $display("FAIL round_%0d: got %0d required %0d", t, got_elem(0,0), cases[t][2]);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    int cases [3][3] = '{'{127, 127, 2047}, '{-128, 127, -2048}, '{3, 5, 7}};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 5; i++) begin
        av[i] = $urandom_range(0, 20) - 10;
        bv[i] = $urandom_range(0, 20) - 10;
      end
      av[0] = cases[t][0];
      bv[0] = cases[t][1];
      pulse_start();
      wait_valid(n);
      n_cmp++;
      if (got_elem(0,0) !== cases[t][2]) begin
        n_bad++; $display("FAIL sat_val%0d: got %0d required %0d", t, got_elem(0,0), cases[t][2]);
      end
      n_cmp++;
      if (error !== (t < 2)) begin
        n_bad++; $display("FAIL sat_err%0d: got %b required %b", t, error, (t < 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [299:0] held;
    randomize_ab();
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    randomize_ab();
    drive_ab();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (n < 40 && valid !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL b2b_latency: got %0d required 9", n); end
    for (int k = 0; k < 25; k++) begin
      n_cmp++;
      if (got_elem(k/5, k%5) !== exp_m[k]) begin
        n_bad++; $display("FAIL b2b_elem%0d: got %0d required %0d", k, got_elem(k/5, k%5), exp_m[k]);
      end
    end
    n_cmp++; if (error !== exp_err) begin n_bad++; $display("FAIL b2b_error: got %b required %b", error, exp_err); end
    held = result;
    randomize_ab();
    drive_ab();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (result !== held) begin n_bad++; $display("FAIL done_hold_result: got %h required %h", result, held); end
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL done_hold_valid: got %b required 1", valid); end
  endtask

  task automatic test_reset_mid();
    int n;
    randomize_ab();
    av[0] = 127;
    bv[0] = -128;
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL mid_err_before: got %b required 1", error); end
    rst = 1'b0;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b required 0", valid); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL mid_error: got %b required 0", error); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL mid_result: got %h required 0", result); end
    @(negedge clk);
    rst = 1'b1;
    randomize_ab();
    pulse_start();
    wait_valid(n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL mid_latency: got %0d required 9", n); end
    for (int k = 0; k < 25; k++) begin
      n_cmp++;
      if (got_elem(k/5, k%5) !== exp_m[k]) begin
        n_bad++; $display("FAIL mid_elem%0d: got %0d required %0d", k, got_elem(k/5, k%5), exp_m[k]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      randomize_ab();
      pulse_start();
      wait_valid(n);
      n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL rand%0d_latency: got %0d required 9", t, n); end
      n_cmp++; if (error !== exp_err) begin n_bad++; $display("FAIL rand%0d_error: got %b required %b", t, error, exp_err); end
      for (int k = 0; k < 25; k++) begin
        n_cmp++;
        if (got_elem(k/5, k%5) !== exp_m[k]) begin
          n_bad++; $display("FAIL rand%0d_elem%0d: got %0d required %0d", t, k, got_elem(k/5, k%5), exp_m[k]);
        end
      end
    end
  endtask

  task automatic test_nonsquare();
    int n;
    bit s;
    for (int t = 0; t < 4; t++) begin
      exp_err2 = 1'b0;
      for (int i = 0; i < 3; i++) av2[i] = $urandom_range(0, 255) - 128;
      for (int i = 0; i < 4; i++) bv2[i] = $urandom_range(0, 255) - 128;
      for (int i = 0; i < 3; i++) a2[i*8 +: 8] = 8'(av2[i]);
      for (int i = 0; i < 4; i++) b2[i*8 +: 8] = 8'(bv2[i]);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++) begin
          exp2[r*4+c] = model_elem(av2[r], bv2[c], s);
          exp_err2 |= s;
        end
      @(posedge clk); #1;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 0;
      while (n < 40) begin
        @(posedge clk); #1;
        n++;
        if (valid2 === 1'b1) break;
      end
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL ns%0d_latency: got %0d required 4", t, n); end
      n_cmp++; if (error2 !== exp_err2) begin n_bad++; $display("FAIL ns%0d_error: got %b required %b", t, error2, exp_err2); end
      for (int k = 0; k < 12; k++) begin
        n_cmp++;
        if (got_elem2(k/4, k%4) !== exp2[k]) begin
          n_bad++; $display("FAIL ns%0d_elem%0d: got %0d required %0d", t, k, got_elem2(k/4, k%4), exp2[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_nonsquare();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
